// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad responder: state encoding, button bit map and defaults.
package nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LATCHED  = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } nes_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NES_NUM_BITS        = 8;
  localparam int NES_TIMEOUT_DEFAULT = 20000;
  localparam int NES_TO_BITS_DEFAULT = 15;

  function automatic int nes_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Two-flop synchronizer with a history flop for edge detection of one async NES pin.
module nes_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic r_hist_p2;

  // Reset to the pin's idle level so releasing reset never looks like an edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync_p0 <= RESET_VAL;
      r_sync_p1 <= RESET_VAL;
      r_hist_p2 <= RESET_VAL;
    end else begin
      r_sync_p0 <= i_async;
      r_sync_p1 <= r_sync_p0;
      r_hist_p2 <= r_sync_p1;
    end
  end

  assign o_level = r_sync_p1;
  assign o_rise  = r_sync_p1 & ~r_hist_p2;
  assign o_fall  = ~r_sync_p1 & r_hist_p2;

endmodule

// File: rtl/nes_pad_responder.sv
// Controller end of the NES pad protocol: captures buttons on latch and shifts them out
// active-low on each NES clock rising edge, with a watchdog that abandons stalled polls.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int NUM_BITS       = NES_NUM_BITS,
  parameter int TIMEOUT_CYCLES = NES_TIMEOUT_DEFAULT,
  parameter int TO_BITS        = NES_TO_BITS_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_BITS-1:0] i_buttons,
  input  logic                i_nes_latch,
  input  logic                i_nes_clk,
  output logic                o_nes_data,
  output logic                o_busy,
  output logic                o_poll_done,
  output logic                o_timeout
);

  localparam int CNT_W = nes_cnt_width(NUM_BITS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NUM_BITS);
  localparam logic [TO_BITS-1:0] WD_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);

  logic w_latch_lvl, w_latch_rise, w_latch_fall;
  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_unused;

  nes_sync_edge #(.RESET_VAL(1'b0)) u_latch_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_nes_latch),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  nes_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_nes_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  assign w_unused = w_clk_lvl ^ w_clk_fall;

  nes_state_t          r_state, w_state_nx;
  logic [NUM_BITS-1:0] r_shift, w_shift_nx, w_shift_dn;
  logic [CNT_W-1:0]    r_bit_cnt, w_cnt_nx, w_cnt_inc;
  logic [TO_BITS-1:0]  r_wd, w_wd_nx;
  logic                r_nes_data, w_data_nx;
  logic                r_poll_done, w_pd_nx;
  logic                r_timeout, w_to_nx;

  assign w_shift_dn = {1'b1, r_shift[NUM_BITS-1:1]};
  assign w_cnt_inc  = r_bit_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_bit_cnt;
    w_wd_nx    = r_wd;
    w_data_nx  = r_nes_data;
    w_pd_nx    = 1'b0;
    w_to_nx    = 1'b0;

    // A latch rise restarts the poll from any state and outranks a coincident clock edge.
    if (w_latch_rise) begin
      w_state_nx = ST_LATCHED;
      w_shift_nx = ~i_buttons;
      w_data_nx  = ~i_buttons[BTN_A];
      w_cnt_nx   = '0;
      w_wd_nx    = '0;
    end else begin
      case (r_state)
        ST_LATCHED: begin
          if (w_latch_fall) begin
            w_state_nx = ST_SHIFTING;
            w_wd_nx    = '0;
          end else if (w_latch_lvl) begin
            w_shift_nx = ~i_buttons;
            w_data_nx  = ~i_buttons[BTN_A];
          end
        end
        ST_SHIFTING: begin
          if (w_clk_rise) begin
            w_shift_nx = w_shift_dn;
            w_cnt_nx   = w_cnt_inc;
            w_wd_nx    = '0;
            if (w_cnt_inc == CNT_LAST) begin
              w_state_nx = ST_DONE;
              w_data_nx  = 1'b1;
              w_pd_nx    = 1'b1;
            end else begin
              w_data_nx  = w_shift_dn[0];
            end
          end else if (r_wd == WD_LAST) begin
            w_state_nx = ST_IDLE;
            w_shift_nx = '1;
            w_data_nx  = 1'b1;
            w_to_nx    = 1'b1;
          end else begin
            w_wd_nx    = r_wd + TO_BITS'(1);
          end
        end
        default: begin
          w_data_nx = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '1;
      r_bit_cnt   <= '0;
      r_wd        <= '0;
      r_nes_data  <= 1'b1;
      r_poll_done <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_shift     <= w_shift_nx;
      r_bit_cnt   <= w_cnt_nx;
      r_wd        <= w_wd_nx;
      r_nes_data  <= w_data_nx;
      r_poll_done <= w_pd_nx;
      r_timeout   <= w_to_nx;
    end
  end

  assign o_nes_data  = r_nes_data;
  assign o_busy      = (r_state == ST_LATCHED) || (r_state == ST_SHIFTING);
  assign o_poll_done = r_poll_done;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: polls, live load, watchdog, re-latch, collisions, reset.
module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buttons;
  logic       latch;
  logic       nclk;
  logic       nes_data, busy, poll_done, timeout;

  int errors = 0;
  int checks = 0;
  int pd_cnt = 0;
  int to_cnt = 0;

  nes_pad_responder dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_buttons   (buttons),
    .i_nes_latch (latch),
    .i_nes_clk   (nclk),
    .o_nes_data  (nes_data),
    .o_busy      (busy),
    .o_poll_done (poll_done),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (poll_done) pd_cnt <= pd_cnt + 1;
    if (timeout)   to_cnt <= to_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nes_rise();
    nclk = 1'b0;
    cyc(6);
    nclk = 1'b1;
    cyc(6);
  endtask

  task automatic latch_poll(input logic [7:0] b);
    buttons = b;
    latch = 1'b1;
    cyc(8);
    latch = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset();
    reset = 1'b1; latch = 1'b0; nclk = 1'b1; buttons = 8'h00;
    cyc(3);
    checks++; if (nes_data !== 1'b1) begin errors++; $display("FAIL reset_data: got %b want 1", nes_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (poll_done !== 1'b0) begin errors++; $display("FAIL reset_pd: got %b want 0", poll_done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b want 0", timeout); end
    reset = 1'b0;
    cyc(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    checks++; if (pd_cnt !== 0) begin errors++; $display("FAIL reset_release_pd: got %0d want 0", pd_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    int pd0;
    exp = 8'b0111_1010;
    pd0 = pd_cnt;
    buttons = 8'h85; latch = 1'b1;
    cyc(8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_latched_busy: got %b want 1", busy); end
    checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL basic_bit0: got %b want 0", nes_data); end
    latch = 1'b0;
    cyc(5);
    checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL basic_bit0_shifting: got %b want 0", nes_data); end
    for (int k = 1; k < 8; k++) begin
      nes_rise();
      checks++; if (nes_data !== exp[k]) begin errors++; $display("FAIL basic_bit%0d: got %b want %b", k, nes_data, exp[k]); end
    end
    nclk = 1'b0;
    cyc(6);
    nclk = 1'b1;
    cyc(2);
    checks++; if (poll_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_pre_done: pd=%b busy=%b want 0,1", poll_done, busy); end
    cyc(1);
    checks++; if (poll_done !== 1'b1 || busy !== 1'b0 || nes_data !== 1'b1) begin
      errors++; $display("FAIL basic_done_edge: pd=%b busy=%b data=%b want 1,0,1", poll_done, busy, nes_data); end
    cyc(1);
    checks++; if (poll_done !== 1'b0) begin errors++; $display("FAIL basic_pd_width: got %b want 0", poll_done); end
    cyc(5);
    checks++; if (pd_cnt - pd0 !== 1) begin errors++; $display("FAIL basic_pd_count: got %0d want 1", pd_cnt - pd0); end
  endtask

  task automatic test_live_load();
    int pd0;
    pd0 = pd_cnt;
    buttons = 8'h00; latch = 1'b1;
    cyc(6);
    checks++; if (nes_data !== 1'b1) begin errors++; $display("FAIL live_initial: got %b want 1", nes_data); end
    buttons = 8'hFF;
    cyc(3);
    checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL live_reload: got %b want 0", nes_data); end
    latch = 1'b0;
    cyc(5);
    buttons = 8'h00;
    for (int k = 1; k < 8; k++) begin
      nes_rise();
      checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL live_bit%0d: got %b want 0", k, nes_data); end
    end
    nes_rise();
    checks++; if (nes_data !== 1'b1) begin errors++; $display("FAIL live_end: got %b want 1", nes_data); end
    checks++; if (pd_cnt - pd0 !== 1) begin errors++; $display("FAIL live_pd_count: got %0d want 1", pd_cnt - pd0); end
  endtask

  task automatic test_watchdog();
    int pd0, to0;
    pd0 = pd_cnt; to0 = to_cnt;
    latch_poll(8'h0F);
    nes_rise();
    nes_rise();
    checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL wd_bit2: got %b want 0", nes_data); end
    nclk = 1'b0;
    cyc(6);
    nclk = 1'b1;
    repeat (20002) @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b0 || busy !== 1'b1 || nes_data !== 1'b0) begin
      errors++; $display("FAIL wd_early: to=%b busy=%b data=%b want 0,1,0", timeout, busy, nes_data); end
    cyc(1);
    checks++; if (timeout !== 1'b1 || busy !== 1'b0 || nes_data !== 1'b1) begin
      errors++; $display("FAIL wd_fire: to=%b busy=%b data=%b want 1,0,1", timeout, busy, nes_data); end
    cyc(1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_width: got %b want 0", timeout); end
    nes_rise();
    checks++; if (busy !== 1'b0 || nes_data !== 1'b1) begin errors++; $display("FAIL wd_idle: busy=%b data=%b want 0,1", busy, nes_data); end
    checks++; if (pd_cnt - pd0 !== 0) begin errors++; $display("FAIL wd_no_pd: got %0d want 0", pd_cnt - pd0); end
    checks++; if (to_cnt - to0 !== 1) begin errors++; $display("FAIL wd_to_count: got %0d want 1", to_cnt - to0); end
  endtask

  task automatic test_relatch();
    logic [7:0] exp1, exp2;
    int pd0;
    exp1 = 8'hF0; exp2 = 8'h0F;
    pd0 = pd_cnt;
    latch_poll(8'h0F);
    for (int k = 1; k <= 4; k++) begin
      nes_rise();
      checks++; if (nes_data !== exp1[k]) begin errors++; $display("FAIL relatch_old_bit%0d: got %b want %b", k, nes_data, exp1[k]); end
    end
    buttons = 8'hF0; latch = 1'b1;
    cyc(4);
    checks++; if (nes_data !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL relatch_load: data=%b busy=%b want 1,1", nes_data, busy); end
    latch = 1'b0;
    cyc(5);
    for (int k = 1; k < 8; k++) begin
      nes_rise();
      checks++; if (nes_data !== exp2[k]) begin errors++; $display("FAIL relatch_new_bit%0d: got %b want %b", k, nes_data, exp2[k]); end
    end
    nes_rise();
    checks++; if (nes_data !== 1'b1) begin errors++; $display("FAIL relatch_end: got %b want 1", nes_data); end
    checks++; if (pd_cnt - pd0 !== 1) begin errors++; $display("FAIL relatch_pd_count: got %0d want 1", pd_cnt - pd0); end
  endtask

  task automatic test_extra_and_simul();
    logic [7:0] exp;
    logic       want;
    int pd0;
    exp = 8'b0111_1010;
    pd0 = pd_cnt;
    latch_poll(8'h85);
    for (int k = 1; k <= 12; k++) begin
      nes_rise();
      want = (k < 8) ? exp[k] : 1'b1;
      checks++; if (nes_data !== want) begin errors++; $display("FAIL extra_bit%0d: got %b want %b", k, nes_data, want); end
    end
    checks++; if (pd_cnt - pd0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL extra_pd: count=%0d busy=%b want 1,0", pd_cnt - pd0, busy); end
    pd0 = pd_cnt;
    latch_poll(8'hFF);
    nes_rise();
    checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL simul_pre: got %b want 0", nes_data); end
    nclk = 1'b0;
    cyc(6);
    buttons = 8'hFE; latch = 1'b1; nclk = 1'b1;
    cyc(3);
    checks++; if (nes_data !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL simul_latch_wins: data=%b busy=%b want 1,1", nes_data, busy); end
    latch = 1'b0;
    cyc(5);
    for (int k = 1; k < 8; k++) begin
      nes_rise();
      checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL simul_bit%0d: got %b want 0", k, nes_data); end
    end
    nes_rise();
    checks++; if (nes_data !== 1'b1) begin errors++; $display("FAIL simul_end: got %b want 1", nes_data); end
    checks++; if (pd_cnt - pd0 !== 1) begin errors++; $display("FAIL simul_pd_count: got %0d want 1", pd_cnt - pd0); end
  endtask

  task automatic test_reset_mid_shift();
    int pd0, to0;
    latch_poll(8'hFF);
    nes_rise();
    nes_rise();
    checks++; if (nes_data !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: data=%b busy=%b want 0,1", nes_data, busy); end
    pd0 = pd_cnt; to0 = to_cnt;
    nclk = 1'b0;
    cyc(3);
    reset = 1'b1; nclk = 1'b1;
    cyc(1);
    checks++; if (nes_data !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_apply: data=%b busy=%b want 1,0", nes_data, busy); end
    cyc(1);
    reset = 1'b0;
    cyc(10);
    checks++; if (nes_data !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_release: data=%b busy=%b want 1,0", nes_data, busy); end
    checks++; if (pd_cnt - pd0 !== 0 || to_cnt - to0 !== 0) begin
      errors++; $display("FAIL rst_mid_pulses: pd=%0d to=%0d want 0,0", pd_cnt - pd0, to_cnt - to0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_live_load();
    test_relatch();
    test_extra_and_simul();
    test_reset_mid_shift();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
